// File: rtl/assoc_branch_target_buffer_pkg.sv
// Shared LC-3b types for the branch target buffer; widths follow the block's
// default geometry (8 sets, 2 ways, 2-bit counters).
package lc3b_types;
  typedef logic [15:0] lc3b_word;

  localparam int BTB_NUM_SETS  = 8;
  localparam int BTB_NUM_WAYS  = 2;
  localparam int BTB_CTR_WIDTH = 2;
  localparam int BTB_IDX_W     = $clog2(BTB_NUM_SETS);
  localparam int BTB_TAG_W     = 15 - BTB_IDX_W;

  typedef logic [BTB_IDX_W-1:0] btb_index;
  typedef logic [BTB_TAG_W-1:0] btb_tag;

  typedef enum logic {
    BTB_IDLE  = 1'b0,
    BTB_FLUSH = 1'b1
  } btb_fsm_state;
endpackage

// File: rtl/assoc_branch_target_buffer_if.sv
// Fetch-side lookup, resolve-side update and flush signals of the BTB.
interface assoc_branch_target_buffer_if;
  import lc3b_types::*;

  lc3b_word lookup_pc;
  logic     lookup_hit;
  logic     predict_taken;
  lc3b_word predicted_target;
  logic     update_valid;
  lc3b_word update_pc;
  lc3b_word update_target;
  logic     update_taken;
  logic     flush;
  logic     flush_busy;

  modport master (
    output lookup_pc, update_valid, update_pc, update_target, update_taken, flush,
    input  lookup_hit, predict_taken, predicted_target, flush_busy
  );

  modport slave (
    input  lookup_pc, update_valid, update_pc, update_target, update_taken, flush,
    output lookup_hit, predict_taken, predicted_target, flush_busy
  );
endinterface

// File: rtl/assoc_branch_target_buffer_set_way.sv
// One way of the BTB: valid/tag/target/counter per set, with a lookup read
// port, an update read port and a single write port.
module btb_set_way
  import lc3b_types::*;
#(
  parameter int NUM_SETS  = BTB_NUM_SETS,
  parameter int IDX_W     = BTB_IDX_W,
  parameter int TAG_W     = BTB_TAG_W,
  parameter int CTR_WIDTH = BTB_CTR_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [IDX_W-1:0]     lk_idx,
  input  logic [TAG_W-1:0]     lk_tag,
  output logic                 lk_hit,
  output lc3b_word             lk_target,
  output logic [CTR_WIDTH-1:0] lk_ctr,
  input  logic [IDX_W-1:0]     up_idx,
  input  logic [TAG_W-1:0]     up_tag,
  output logic                 up_valid,
  output logic                 up_hit,
  output logic [CTR_WIDTH-1:0] up_ctr,
  input  logic                 wr_en,
  input  lc3b_word             wr_target,
  input  logic [CTR_WIDTH-1:0] wr_ctr,
  input  logic                 clr_en,
  input  logic [IDX_W-1:0]     clr_idx
);
  logic [NUM_SETS-1:0]  valid;
  logic [TAG_W-1:0]     tag    [NUM_SETS];
  lc3b_word             target [NUM_SETS];
  logic [CTR_WIDTH-1:0] ctr    [NUM_SETS];

  // Reads are combinational, so a same-cycle write is only seen next cycle.
  assign lk_hit    = valid[lk_idx] && (tag[lk_idx] == lk_tag);
  assign lk_target = lk_hit ? target[lk_idx] : '0;
  assign lk_ctr    = ctr[lk_idx];
  assign up_valid  = valid[up_idx];
  assign up_hit    = valid[up_idx] && (tag[up_idx] == up_tag);
  assign up_ctr    = ctr[up_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= '0;
    end else if (clr_en) begin
      valid[clr_idx] <= 1'b0;
    end else if (wr_en) begin
      valid[up_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag[up_idx]    <= up_tag;
      target[up_idx] <= wr_target;
      ctr[up_idx]    <= wr_ctr;
    end
  end
endmodule

// File: rtl/assoc_branch_target_buffer.sv
// Set-associative branch target buffer with saturating direction counters,
// round-robin replacement and a one-set-per-cycle flush walk.
module assoc_branch_target_buffer
  import lc3b_types::*;
#(
  parameter int NUM_SETS  = BTB_NUM_SETS,
  parameter int NUM_WAYS  = BTB_NUM_WAYS,
  parameter int CTR_WIDTH = BTB_CTR_WIDTH
) (
  input  logic clk,
  input  logic reset_n,
  assoc_branch_target_buffer_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 15 - IDX_W;
  localparam int PTR_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'(1) << (CTR_WIDTH - 1);

  btb_fsm_state         state;
  logic [IDX_W-1:0]     flush_idx;
  logic                 flush_busy_q;

  logic [IDX_W-1:0]     lk_idx, up_idx;
  logic [TAG_W-1:0]     lk_tag, up_tag;

  logic [NUM_WAYS-1:0]                lk_hit, up_valid, up_hit, wr_en;
  logic [NUM_WAYS-1:0][15:0]          lk_target;
  logic [NUM_WAYS-1:0][CTR_WIDTH-1:0] lk_ctr, up_ctr;

  logic                 lk_any;
  lc3b_word             lk_sel_target;
  logic [CTR_WIDTH-1:0] lk_sel_ctr;
  logic                 upd_en, upd_any, alloc, set_full;
  logic [CTR_WIDTH-1:0] hit_ctr, wr_ctr;
  logic [PTR_W-1:0]     victim;
  logic [NUM_SETS-1:0][PTR_W-1:0] rr_ptr;

  logic                 hit_q, taken_q;
  lc3b_word             target_q;
  logic                 unused_pc_lsb;

  assign lk_idx = bus.lookup_pc[IDX_W:1];
  assign lk_tag = bus.lookup_pc[15:IDX_W+1];
  assign up_idx = bus.update_pc[IDX_W:1];
  assign up_tag = bus.update_pc[15:IDX_W+1];
  assign unused_pc_lsb = bus.lookup_pc[0] ^ bus.update_pc[0];

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    btb_set_way #(
      .NUM_SETS (NUM_SETS),
      .IDX_W    (IDX_W),
      .TAG_W    (TAG_W),
      .CTR_WIDTH(CTR_WIDTH)
    ) u_way (
      .clk      (clk),
      .reset_n  (reset_n),
      .lk_idx   (lk_idx),
      .lk_tag   (lk_tag),
      .lk_hit   (lk_hit[w]),
      .lk_target(lk_target[w]),
      .lk_ctr   (lk_ctr[w]),
      .up_idx   (up_idx),
      .up_tag   (up_tag),
      .up_valid (up_valid[w]),
      .up_hit   (up_hit[w]),
      .up_ctr   (up_ctr[w]),
      .wr_en    (wr_en[w]),
      .wr_target(bus.update_target),
      .wr_ctr   (wr_ctr),
      .clr_en   (state == BTB_FLUSH),
      .clr_idx  (flush_idx)
    );
    assign wr_en[w] = upd_en && (upd_any ? up_hit[w] : (alloc && victim == PTR_W'(w)));
  end

  // At most one way matches, so an OR-reduce acts as the way mux.
  always_comb begin
    lk_any        = 1'b0;
    lk_sel_target = '0;
    lk_sel_ctr    = '0;
    hit_ctr       = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (lk_hit[w]) begin
        lk_any        = 1'b1;
        lk_sel_target = lk_sel_target | lk_target[w];
        lk_sel_ctr    = lk_sel_ctr | lk_ctr[w];
      end
      if (up_hit[w]) hit_ctr = hit_ctr | up_ctr[w];
    end
  end

  // Lowest invalid way wins; otherwise fall back to the set's round-robin way.
  always_comb begin
    victim = rr_ptr[up_idx];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!up_valid[w]) victim = PTR_W'(w);
    end
  end

  assign upd_en   = bus.update_valid && (state == BTB_IDLE);
  assign upd_any  = |up_hit;
  assign set_full = &up_valid;
  assign alloc    = upd_en && !upd_any && bus.update_taken;

  always_comb begin
    wr_ctr = CTR_INIT;
    if (upd_any) begin
      if (bus.update_taken) wr_ctr = (hit_ctr == CTR_MAX) ? CTR_MAX : hit_ctr + CTR_WIDTH'(1);
      else                  wr_ctr = (hit_ctr == '0) ? '0 : hit_ctr - CTR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (alloc && set_full) begin
      rr_ptr[up_idx] <= (rr_ptr[up_idx] == PTR_W'(NUM_WAYS - 1)) ? '0
                                                                 : rr_ptr[up_idx] + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= BTB_IDLE;
      flush_idx    <= '0;
      flush_busy_q <= 1'b0;
    end else begin
      case (state)
        BTB_IDLE: begin
          if (bus.flush) begin
            state        <= BTB_FLUSH;
            flush_idx    <= '0;
            flush_busy_q <= 1'b1;
          end
        end
        BTB_FLUSH: begin
          if (flush_idx == IDX_W'(NUM_SETS - 1)) begin
            state        <= BTB_IDLE;
            flush_busy_q <= 1'b0;
          end else begin
            flush_idx <= flush_idx + IDX_W'(1);
          end
        end
        default: begin
          state        <= BTB_IDLE;
          flush_busy_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_q    <= 1'b0;
      taken_q  <= 1'b0;
      target_q <= '0;
    end else if (state == BTB_IDLE) begin
      hit_q    <= lk_any;
      taken_q  <= lk_any && lk_sel_ctr[CTR_WIDTH-1];
      target_q <= lk_sel_target;
    end else begin
      hit_q    <= 1'b0;
      taken_q  <= 1'b0;
      target_q <= '0;
    end
  end

  assign bus.lookup_hit       = hit_q;
  assign bus.predict_taken    = taken_q;
  assign bus.predicted_target = target_q;
  assign bus.flush_busy       = flush_busy_q;
endmodule

// File: tb/tb_assoc_branch_target_buffer.sv
// Directed scoreboard bench for the BTB: lookups push expected {hit,taken,target},
// a monitor pops and compares one cycle after each lookup is captured.
module tb_assoc_branch_target_buffer;
  import lc3b_types::*;

  typedef struct {
    string       name;
    logic [17:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  assoc_branch_target_buffer_if bus();

  assoc_branch_target_buffer #(
    .NUM_SETS (8),
    .NUM_WAYS (2),
    .CTR_WIDTH(2)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  logic lk_req = 1'b0;
  logic lk_pend = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) lk_pend <= 1'b0;
    else          lk_pend <= lk_req;
  end

  always @(negedge clk) begin
    exp_t e;
    if (lk_pend) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: lookup response with no expectation queued");
      end else begin
        e = exp_q.pop_front();
        check(e.name, {14'd0, bus.lookup_hit, bus.predict_taken, bus.predicted_target},
              {14'd0, e.v});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string nm, input logic h, input logic t, input lc3b_word tg);
    exp_t e;
    e.name = nm;
    e.v    = {h, t, tg};
    exp_q.push_back(e);
  endtask

  task automatic lookup(input string nm, input lc3b_word pc, input logic h, input logic t,
                        input lc3b_word tg);
    bus.lookup_pc = pc;
    lk_req = 1'b1;
    push_exp(nm, h, t, tg);
    step();
    lk_req = 1'b0;
  endtask

  task automatic update(input lc3b_word pc, input lc3b_word tg, input logic taken);
    bus.update_pc     = pc;
    bus.update_target = tg;
    bus.update_taken  = taken;
    bus.update_valid  = 1'b1;
    step();
    bus.update_valid  = 1'b0;
  endtask

  initial begin
    int n;
    bus.lookup_pc     = '0;
    bus.update_valid  = 1'b0;
    bus.update_pc     = '0;
    bus.update_target = '0;
    bus.update_taken  = 1'b0;
    bus.flush         = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {14'd0, bus.lookup_hit, bus.predict_taken, bus.predicted_target}, 32'd0);
    check("rst_busy", {31'd0, bus.flush_busy}, 32'd0);
    reset_n = 1'b1;
    step();

    lookup("first_miss", 16'h3000, 1'b0, 1'b0, 16'h0000);

    update(16'h3002, 16'h3100, 1'b1);
    lookup("alloc_hit", 16'h3002, 1'b1, 1'b1, 16'h3100);

    // Counter 2 -> 1 -> 0 -> 0 (floor), then taken -> 1 (no wrap through 3)
    update(16'h3002, 16'h3100, 1'b0);
    lookup("nt1", 16'h3002, 1'b1, 1'b0, 16'h3100);
    update(16'h3002, 16'h3100, 1'b0);
    lookup("nt2", 16'h3002, 1'b1, 1'b0, 16'h3100);
    update(16'h3002, 16'h3100, 1'b0);
    lookup("nt3", 16'h3002, 1'b1, 1'b0, 16'h3100);
    update(16'h3002, 16'h3100, 1'b0);
    update(16'h3002, 16'h3100, 1'b1);
    lookup("floor_sat", 16'h3002, 1'b1, 1'b0, 16'h3100);

    // Counter 1 -> 2 with new target, 3, 3 (ceiling), 2, 1
    update(16'h3002, 16'h3200, 1'b1);
    lookup("retarget", 16'h3002, 1'b1, 1'b1, 16'h3200);
    update(16'h3002, 16'h3200, 1'b1);
    update(16'h3002, 16'h3200, 1'b1);
    update(16'h3002, 16'h3200, 1'b0);
    lookup("ceil_sat_a", 16'h3002, 1'b1, 1'b1, 16'h3200);
    update(16'h3002, 16'h3200, 1'b0);
    lookup("ceil_sat_b", 16'h3002, 1'b1, 1'b0, 16'h3200);

    update(16'h5006, 16'h5100, 1'b0);
    lookup("nt_miss_noalloc", 16'h5006, 1'b0, 1'b0, 16'h0000);

    // Set 1: 0x3012 fills way1, 0x3022 evicts way0 (0x3002), 0x3032 evicts way1
    update(16'h3012, 16'h3112, 1'b1);
    update(16'h3022, 16'h3122, 1'b1);
    lookup("evict_3002", 16'h3002, 1'b0, 1'b0, 16'h0000);
    lookup("keep_3012", 16'h3012, 1'b1, 1'b1, 16'h3112);
    lookup("keep_3022", 16'h3022, 1'b1, 1'b1, 16'h3122);
    update(16'h3032, 16'h3132, 1'b1);
    lookup("rr_evict_3012", 16'h3012, 1'b0, 1'b0, 16'h0000);
    lookup("rr_keep_3022", 16'h3022, 1'b1, 1'b1, 16'h3122);
    lookup("rr_new_3032", 16'h3032, 1'b1, 1'b1, 16'h3132);

    bus.update_pc     = 16'h4004;
    bus.update_target = 16'h4104;
    bus.update_taken  = 1'b1;
    bus.update_valid  = 1'b1;
    lookup("same_cycle_miss", 16'h4004, 1'b0, 1'b0, 16'h0000);
    bus.update_valid  = 1'b0;
    lookup("same_cycle_next", 16'h4004, 1'b1, 1'b1, 16'h4104);

    for (int s = 0; s < 8; s++) update(16'h6000 + 16'(2 * s), 16'h6800 + 16'(2 * s), 1'b1);
    for (int s = 0; s < 8; s++)
      lookup("fill_hit", 16'h6000 + 16'(2 * s), 1'b1, 1'b1, 16'h6800 + 16'(2 * s));

    // Flush walk; mid-walk lookup is forced to miss, update and re-flush are ignored
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    n = 0;
    while (bus.flush_busy === 1'b1 && n < 100) begin
      n++;
      if (n == 2) begin
        bus.lookup_pc = 16'h6000;
        lk_req = 1'b1;
        push_exp("flush_forced_miss", 1'b0, 1'b0, 16'h0000);
      end
      if (n == 3) begin
        bus.update_pc     = 16'h7000;
        bus.update_target = 16'h7100;
        bus.update_taken  = 1'b1;
        bus.update_valid  = 1'b1;
      end
      if (n == 4) bus.flush = 1'b1;
      step();
      lk_req = 1'b0;
      bus.update_valid = 1'b0;
      bus.flush = 1'b0;
    end
    check("flush_busy_cycles", n, 32'd8);
    for (int s = 0; s < 8; s++)
      lookup("post_flush_miss", 16'h6000 + 16'(2 * s), 1'b0, 1'b0, 16'h0000);
    lookup("flush_update_dropped", 16'h7000, 1'b0, 1'b0, 16'h0000);
    lookup("flush_4004_miss", 16'h4004, 1'b0, 1'b0, 16'h0000);

    // Reset in the middle of a flush walk
    update(16'h6000, 16'h6900, 1'b1);
    update(16'h600E, 16'h690E, 1'b1);
    lookup("refill_hit", 16'h600E, 1'b1, 1'b1, 16'h690E);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    step();
    step();
    check("mid_flush_busy", {31'd0, bus.flush_busy}, 32'd1);
    reset_n = 1'b0;
    #2;
    check("mid_rst_outputs", {14'd0, bus.lookup_hit, bus.predict_taken, bus.predicted_target},
          32'd0);
    check("mid_rst_busy", {31'd0, bus.flush_busy}, 32'd0);
    step();
    reset_n = 1'b1;
    step();
    check("post_rst_busy", {31'd0, bus.flush_busy}, 32'd0);
    lookup("post_rst_miss_0", 16'h6000, 1'b0, 1'b0, 16'h0000);
    lookup("post_rst_miss_7", 16'h600E, 1'b0, 1'b0, 16'h0000);
    update(16'h6000, 16'h6A00, 1'b1);
    lookup("post_rst_idle_alloc", 16'h6000, 1'b1, 1'b1, 16'h6A00);
    check("post_rst_still_idle", {31'd0, bus.flush_busy}, 32'd0);

    repeat (3) step();
    check("sb_drain", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/assoc_branch_target_buffer.md
ASSOC_BRANCH_TARGET_BUFFER -- requirements
Module: assoc_branch_target_buffer

Interface
REQ-001 Parameter NUM_SETS, 8, number of sets; power of two, 2..64.
REQ-002 Parameter NUM_WAYS, 2, ways per set; one of 1, 2, 4.
REQ-003 Parameter CTR_WIDTH, 2, saturating-counter width per entry.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 lookup_pc  in  16 (lc3b_word)  fetch PC to predict.
REQ-007 lookup_hit  out  1  registered; lookup_pc of previous cycle hit a valid entry.
REQ-008 predict_taken  out  1  registered; MSB of hit entry's counter, 0 on miss.
REQ-009 predicted_target  out  16  registered; hit entry's target, 0 on miss.
REQ-010 update_valid  in  1  resolved branch presented this cycle.
REQ-011 update_pc, update_target  in  16 each  resolved branch PC and target.
REQ-012 update_taken  in  1  resolved outcome.
REQ-013 flush  in  1  single-cycle invalidate-all request.
REQ-014 flush_busy  out  1  high while flush walk in progress.

Function
REQ-015 Index = pc[IDX_W:1], IDX_W = log2(NUM_SETS); tag = pc[15:IDX_W+1]; pc[0] ignored.
REQ-016 Lookup latency exactly 1 cycle; all ways of indexed set compared in parallel; at most one way matches.
REQ-017 Lookup and update to same set in same cycle: lookup returns pre-update contents.
REQ-018 Update hit: target overwritten; counter +1 if taken, -1 if not taken, saturating at 0 and 2^CTR_WIDTH-1.
REQ-019 Update miss with update_taken=1: allocate; victim = lowest-numbered invalid way, else way at per-set round-robin pointer; new counter = 2^(CTR_WIDTH-1) (weakly taken).
REQ-020 Round-robin pointer advances (mod NUM_WAYS) only on allocation into a fully valid set.
REQ-021 Update miss with update_taken=0: no state change.
REQ-022 FSM states IDLE, FLUSH; IDLE->FLUSH on flush; FLUSH clears valid bits of one set per cycle, set 0 upward; FLUSH->IDLE after set NUM_SETS-1 cleared (NUM_SETS cycles).
REQ-023 In FLUSH: lookup outputs forced 0, updates dropped, further flush ignored.
REQ-024 Targets and counters need no reset; only valid bits, pointers, FSM and registered outputs reset.

Reset
REQ-025 reset_n low: all valid bits 0, round-robin pointers 0, FSM IDLE, flush_busy 0, lookup_hit 0, predict_taken 0, predicted_target 0x0000.
REQ-026 Reset asserted mid-flush aborts walk; on release block is IDLE with all entries invalid.
REQ-027 First lookup after reset release returns miss.

Structure
REQ-028 btb_tag, btb_index, and btb_fsm_state enum live in lc3b_types, widths derived from the block's default parameters.
REQ-029 One sub-module btb_set_way holding valid/tag/target/counter arrays for one way, instantiated NUM_WAYS times.

Verification
REQ-030 Reset, lookup 0x3000 -> next-cycle hit=0, predict_taken=0, target=0x0000.
REQ-031 Update pc=0x3002, target=0x3100, taken; lookup 0x3002 -> hit=1, predict_taken=1, target=0x3100.
REQ-032 Three not-taken updates to 0x3002 -> counter 0, predict_taken=0, hit=1; further not-taken keeps 0.
REQ-033 NUM_WAYS=2: allocate 0x3002, 0x3012, 0x3022 (same set) -> 0x3002 evicted, other two hit.
REQ-034 Same-cycle lookup and first update of 0x4004 -> lookup misses; lookup next cycle hits.
REQ-035 Fill table, pulse flush -> flush_busy high exactly NUM_SETS cycles, all lookups miss after; reset_n pulsed mid-flush -> IDLE, all miss.
